// File: rtl/uart_frame_pkg.sv
// Shared types for the UART frame parser: FSM state encoding and error codes.
// Optional checksum byte is enabled by defining UART_FRAME_CSUM_EN.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        S_HDR0    = 3'd0,
        S_HDR1    = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4,
        S_OUT     = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_IDLE = 2'd3;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: simple dual-port RAM, one write port and a registered read
// port with one cycle of latency. The read register holds when rd_en is low.
module uart_frame_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame sequencer behind the UART byte receiver: header, length, payload and
// (when UART_FRAME_CSUM_EN is defined) checksum, then a ready/valid payload replay.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN = 64,
    parameter logic [7:0] HDR0    = 8'h55,
    parameter logic [7:0] HDR1    = 8'hAA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    input  logic        rx_frame_ack,
    output logic [7:0]  frm_data,
    output logic        frm_valid,
    input  logic        frm_ready,
    output logic        frm_last,
    output logic        frm_ok,
    output logic        frm_err,
    output logic [1:0]  err_code,
    output logic [15:0] drop_cnt,
    output logic        busy
);

    localparam int         ADDR_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t      state;
    logic [7:0]  len;
    logic [7:0]  wr_ptr;
    logic [7:0]  rd_ptr;
    logic        wr_en;
    logic        rd_en;
    logic        byte_in;
    logic        last_wr;
`ifdef UART_FRAME_CSUM_EN
    logic [7:0]  csum;
`endif

    // A beat transfers on a rising edge where frm_valid && frm_ready; while
    // frm_valid is high and frm_ready low, frm_data/frm_last hold and frm_valid
    // stays high. A new byte is fetched whenever the output slot is empty or
    // draining, giving one beat per cycle under constant frm_ready.
    assign byte_in = rx_data_valid && !rx_frame_ack;
    assign wr_en   = (state == S_PAYLOAD) && byte_in;
    assign last_wr = (wr_ptr == len - 8'd1);
    assign rd_en   = (state == S_OUT) && (rd_ptr != len) && (!frm_valid || frm_ready);
    assign busy    = (state != S_HDR0);

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (rx_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (frm_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_HDR0;
            len       <= 8'd0;
            wr_ptr    <= 8'd0;
            rd_ptr    <= 8'd0;
            frm_valid <= 1'b0;
            frm_last  <= 1'b0;
            frm_ok    <= 1'b0;
            frm_err   <= 1'b0;
            err_code  <= ERR_NONE;
            drop_cnt  <= 16'd0;
`ifdef UART_FRAME_CSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            frm_ok  <= 1'b0;
            frm_err <= 1'b0;

            if (rd_en) begin
                rd_ptr    <= rd_ptr + 8'd1;
                frm_valid <= 1'b1;
                frm_last  <= (rd_ptr == len - 8'd1);
            end else if (frm_ready) begin
                frm_valid <= 1'b0;
                frm_last  <= 1'b0;
            end

            case (state)
                S_HDR0: begin
                    if (byte_in && rx_data == HDR0) state <= S_HDR1;
                end
                S_HDR1: begin
                    if (rx_frame_ack) begin
                        state <= S_HDR0;
                    end else if (rx_data_valid) begin
                        if (rx_data == HDR1)      state <= S_LEN;
                        else if (rx_data != HDR0) state <= S_HDR0;
                    end
                end
                S_LEN: begin
                    if (rx_frame_ack) begin
                        frm_err  <= 1'b1;
                        err_code <= ERR_IDLE;
                        state    <= S_HDR0;
                    end else if (rx_data_valid) begin
                        len <= rx_data;
`ifdef UART_FRAME_CSUM_EN
                        csum <= rx_data;
`endif
                        if (rx_data > MAX_LEN_B) begin
                            frm_err  <= 1'b1;
                            err_code <= ERR_LEN;
                            state    <= S_HDR0;
                        end else if (rx_data == 8'd0) begin
`ifdef UART_FRAME_CSUM_EN
                            state  <= S_CSUM;
`else
                            frm_ok <= 1'b1;
                            state  <= S_HDR0;
`endif
                        end else begin
                            wr_ptr <= 8'd0;
                            state  <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (rx_frame_ack) begin
                        frm_err  <= 1'b1;
                        err_code <= ERR_IDLE;
                        state    <= S_HDR0;
                    end else if (rx_data_valid) begin
                        wr_ptr <= wr_ptr + 8'd1;
`ifdef UART_FRAME_CSUM_EN
                        csum <= csum + rx_data;
                        if (last_wr) state <= S_CSUM;
`else
                        if (last_wr) begin
                            frm_ok <= 1'b1;
                            rd_ptr <= 8'd0;
                            state  <= S_OUT;
                        end
`endif
                    end
                end
`ifdef UART_FRAME_CSUM_EN
                S_CSUM: begin
                    if (rx_frame_ack) begin
                        frm_err  <= 1'b1;
                        err_code <= ERR_IDLE;
                        state    <= S_HDR0;
                    end else if (rx_data_valid) begin
                        if (rx_data == csum) begin
                            frm_ok <= 1'b1;
                            if (len != 8'd0) begin
                                rd_ptr <= 8'd0;
                                state  <= S_OUT;
                            end else begin
                                state <= S_HDR0;
                            end
                        end else begin
                            frm_err  <= 1'b1;
                            err_code <= ERR_CSUM;
                            state    <= S_HDR0;
                        end
                    end
                end
`endif
                S_OUT: begin
                    // Receiver keeps running while we replay; its bytes are lost.
                    if (byte_in && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                    if (frm_valid && frm_ready && frm_last) state <= S_HDR0;
                end
                default: state <= S_HDR0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser; adapts expectations to UART_FRAME_CSUM_EN.
module tb_uart_frame_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_data_valid = 1'b0;
    logic        rx_frame_ack = 1'b0;
    logic [7:0]  frm_data;
    logic        frm_valid;
    logic        frm_ready = 1'b1;
    logic        frm_last;
    logic        frm_ok;
    logic        frm_err;
    logic [1:0]  err_code;
    logic [15:0] drop_cnt;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    logic       stalled = 1'b0;
    logic [8:0] stall_beat = 9'd0;

    uart_frame_parser dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_frame_ack  (rx_frame_ack),
        .frm_data      (frm_data),
        .frm_valid     (frm_valid),
        .frm_ready     (frm_ready),
        .frm_last      (frm_last),
        .frm_ok        (frm_ok),
        .frm_err       (frm_err),
        .err_code      (err_code),
        .drop_cnt      (drop_cnt),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled) begin
                check("stall_valid", 32'(frm_valid), 32'd1);
                check("stall_beat", 32'({frm_last, frm_data}), 32'(stall_beat));
            end
            if (frm_valid && frm_ready) got_q.push_back({frm_last, frm_data});
            stalled    = frm_valid && !frm_ready;
            stall_beat = {frm_last, frm_data};
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data       = b;
        rx_data_valid = 1'b1;
        @(posedge clk); #1;
        rx_data_valid = 1'b0;
    endtask

    task automatic pulse_ack();
        rx_frame_ack = 1'b1;
        @(posedge clk); #1;
        rx_frame_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic expect_beats(input int n);
        int cyc = 0;
        while (got_q.size() < n && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("beat_count", 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (got_q.size() > 0 && exp_q.size() > 0)
                check($sformatf("beat%0d", i), 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (busy && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("idle", 32'(busy), 32'd0);
    endtask

    task automatic send_good3();
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
`ifdef UART_FRAME_CSUM_EN
        send_byte(8'h69);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        // Reset
        idle(3);
        rst_n = 1'b1;
        #1;
        check("rst_valid", 32'(frm_valid), 32'd0);
        check("rst_last",  32'(frm_last),  32'd0);
        check("rst_ok",    32'(frm_ok),    32'd0);
        check("rst_err",   32'(frm_err),   32'd0);
        check("rst_code",  32'(err_code),  32'd0);
        check("rst_drop",  32'(drop_cnt),  32'd0);
        check("rst_data",  32'(frm_data),  32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        idle(1);

        // Good 3-byte frame, sink always ready
        frm_ready = 1'b1;
        send_byte(8'h55);
        check("hdr_busy", 32'(busy), 32'd1);
        send_byte(8'hAA); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
`ifdef UART_FRAME_CSUM_EN
        send_byte(8'h69);
`endif
        check("t1_ok",  32'(frm_ok),  32'd1);
        check("t1_err", 32'(frm_err), 32'd0);
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        expect_beats(3);
        check("t1_code", 32'(err_code), 32'd0);
        wait_idle();

`ifdef UART_FRAME_CSUM_EN
        // Bad checksum
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h6A);
        check("t2_err",  32'(frm_err),  32'd1);
        check("t2_ok",   32'(frm_ok),   32'd0);
        check("t2_code", 32'(err_code), 32'd2);
        idle(6);
        check("t2_nobeat", 32'(got_q.size()), 32'd0);
        check("t2_busy",   32'(busy),         32'd0);
`endif

        // Length above MAX_LEN
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h41);
        check("t3_err",  32'(frm_err),  32'd1);
        check("t3_code", 32'(err_code), 32'd1);
        check("t3_busy", 32'(busy),     32'd0);
        idle(1);
        check("t3_pulse", 32'(frm_err), 32'd0);

        // Idle timeout mid-payload, then a clean 1-byte frame
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h04);
        send_byte(8'h01); send_byte(8'h02);
        pulse_ack();
        check("t4_err",  32'(frm_err),  32'd1);
        check("t4_code", 32'(err_code), 32'd3);
        check("t4_busy", 32'(busy),     32'd0);
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01); send_byte(8'h7E);
`ifdef UART_FRAME_CSUM_EN
        send_byte(8'h7F);
`endif
        check("t4_ok", 32'(frm_ok), 32'd1);
        exp_q.push_back({1'b1, 8'h7E});
        expect_beats(1);
        check("t4_code_held", 32'(err_code), 32'd3);
        wait_idle();

        // Back-pressure with bytes dropped during replay
        frm_ready = 1'b0;
        send_good3();
        check("t5_ok", 32'(frm_ok), 32'd1);
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
        send_byte(8'h01); send_byte(8'h02);
        idle(5);
        check("t5_valid", 32'(frm_valid), 32'd1);
        check("t5_data",  32'(frm_data),  32'h11);
        check("t5_last",  32'(frm_last),  32'd0);
        check("t5_drop",  32'(drop_cnt),  32'd5);
        // Same-cycle ack and byte: byte discarded, not counted
        rx_frame_ack = 1'b1;
        send_byte(8'h99);
        rx_frame_ack = 1'b0;
        check("t5_drop_ack", 32'(drop_cnt), 32'd5);
        frm_ready = 1'b1;
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        expect_beats(3);
        wait_idle();

        // Zero-length frame with a repeated first header byte
        send_byte(8'h55); send_byte(8'h55); send_byte(8'hAA); send_byte(8'h00);
`ifdef UART_FRAME_CSUM_EN
        check("t6_busy_csum", 32'(busy), 32'd1);
        send_byte(8'h00);
`endif
        check("t6_ok",   32'(frm_ok),  32'd1);
        check("t6_busy", 32'(busy),    32'd0);
        idle(6);
        check("t6_nobeat", 32'(got_q.size()), 32'd0);

        // Line idle in S_HDR1 returns silently to S_HDR0
        send_byte(8'h55);
        pulse_ack();
        check("t7_err",  32'(frm_err), 32'd0);
        check("t7_busy", 32'(busy),    32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Controller downstream of the UART byte receiver. Consumes the byte stream (data plus valid pulse) and the frame-idle pulse, then sequences frame reception: header, length, payload, checksum. Payload goes into an internal buffer. It is released as a ready/valid stream only after the frame checks good. Parse errors and idle timeouts abort the frame and are reported as error pulses with a code.

Parameters:
MAX_LEN, 64, maximum payload bytes (1..255); buffer depth
HDR0, 8'h55, first header byte
HDR1, 8'hAA, second header byte
ADDR_W, $clog2(MAX_LEN), localparam, buffer address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte, valid when rx_data_valid=1
rx_data_valid  in  1  one-cycle pulse per received byte
rx_frame_ack  in  1  one-cycle line-idle pulse from receiver
frm_data  out  8  payload byte
frm_valid  out  1  payload beat valid
frm_ready  in  1  sink accepts beat
frm_last  out  1  final payload beat
frm_ok  out  1  one-cycle pulse: frame accepted
frm_err  out  1  one-cycle pulse: frame rejected
err_code  out  2  1=length>MAX_LEN, 2=checksum, 3=idle timeout; held until next frm_err
drop_cnt  out  16  bytes dropped while in S_OUT, saturating at 16'hFFFF
busy  out  1  state != S_HDR0

Behaviour:
- Reset: state S_HDR0. frm_valid, frm_last, frm_ok, frm_err = 0. err_code = 0, drop_cnt = 0, frm_data = 0. Buffer contents are don't-care.
- States, evaluated only on rx_data_valid unless noted:
  - S_HDR0: byte==HDR0 -> S_HDR1; else stay.
  - S_HDR1: byte==HDR1 -> S_LEN. byte==HDR0 -> stay in S_HDR1. Else -> S_HDR0. No error is reported in either header state.
  - S_LEN: latch len and set csum=len.
    - len > MAX_LEN -> frm_err, code 1, S_HDR0.
    - len==0 -> S_CSUM.
    - Else -> S_PAYLOAD with wr_ptr=0.
  - S_PAYLOAD: write byte at wr_ptr, csum += byte (mod 256), wr_ptr++. When wr_ptr reaches len-1 on this byte -> S_CSUM.
  - S_CSUM: byte==csum -> frm_ok pulse next cycle.
    - If len>0 -> S_OUT with rd_ptr=0.
    - If len==0 -> S_HDR0.
    - byte!=csum -> frm_err, code 2, S_HDR0.
  - S_OUT: stream len bytes. Buffer read latency is 1 cycle. First frm_valid is asserted no later than 2 cycles after entering S_OUT. frm_last=1 on beat len-1. When the last beat is accepted (frm_valid & frm_ready & frm_last) -> S_HDR0 next cycle.
- Handshake: frm_data and frm_last stay stable while frm_valid & !frm_ready. Back-to-back beats run at 1/cycle when frm_ready is held high. frm_valid never drops without a transfer.
- In S_OUT, incoming rx bytes are not parsed and drop_cnt increments; the following frame may be lost.
- rx_frame_ack:
  - In S_LEN, S_PAYLOAD or S_CSUM: abort -> frm_err, code 3, S_HDR0.
  - In S_HDR1: silently -> S_HDR0.
  - In S_HDR0 and S_OUT: ignored.
- If rx_frame_ack and rx_data_valid occur in the same cycle, the ack wins and the byte is discarded (it is not counted in drop_cnt).
- frm_ok and frm_err are mutually exclusive and each lasts exactly one cycle. Each is registered, one cycle after the deciding byte.
- Async reset during S_OUT drops the frame immediately; frm_valid goes to 0.

Optional Feature:
UART_FRAME_CSUM_EN
- Defined: frame carries the checksum byte as above; error code 2 is possible.
- Undefined: no checksum byte and no S_CSUM state.
  - After the last payload byte -> frm_ok and S_OUT.
  - len==0 -> frm_ok and S_HDR0 directly after S_LEN.
  - err_code 2 never occurs.

Decomposition:
- Package uart_frame_pkg: state enum (S_HDR0, S_HDR1, S_LEN, S_PAYLOAD, S_CSUM, S_OUT), err_code constants ERR_LEN=1, ERR_CSUM=2, ERR_IDLE=3.
- Sub-module uart_frame_buf: simple dual-port RAM, MAX_LEN x 8, one write port, registered read port with 1-cycle latency.

Test Plan:
- Bytes 55 AA 03 11 22 33 69, frm_ready=1 -> frm_ok; beats 11,22,33 with frm_last on 33; err_code unchanged.
- Same frame with checksum 6A -> frm_err, err_code=2, no frm_valid.
- 55 AA 41 (len 65 > MAX_LEN 64) -> frm_err, err_code=1, busy=0 next cycle.
- 55 AA 04 01 02 then rx_frame_ack -> frm_err, err_code=3; following 55 AA 01 7E 7F parses -> frm_ok, beat 7E.
- Good 3-byte frame with frm_ready low for 10 cycles while 5 bytes arrive -> frm_data stable at 11, drop_cnt=5, then all 3 beats delivered.
- 55 55 AA 00 00 -> frm_ok, zero beats, back to S_HDR0. Without UART_FRAME_CSUM_EN, 55 AA 00 -> frm_ok.
